// File: rtl/li_expander_if.sv
// Request/instruction handshake bundle for li_expander.
// The slave side is the expander; the master side issues constants and consumes words.
interface li_expander_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [31:0] req_value;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_last;

  modport master (
    output req_valid, req_rd, req_value, inst_ready,
    input  req_ready, inst_valid, inst, inst_last
  );

  modport slave (
    input  req_valid, req_rd, req_value, inst_ready,
    output req_ready, inst_valid, inst, inst_last
  );
endinterface

// File: rtl/li_expander.sv
// li_expander: turns a 32-bit constant and destination register into the RV32I
// ADDI / LUI / LUI+ADDI sequence that rebuilds that constant in rd.
module li_expander #(
  parameter bit SKIP_ZERO_LO = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET,
  li_expander_if.slave bus,
  output logic         busy
);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EMIT_FIRST = 2'd1,
    EMIT_ADDI  = 2'd2
  } state_t;

  // Rounding by 0x800 pre-compensates for ADDI sign-extending its 12-bit immediate.
  function automatic logic [19:0] split_hi(input logic [31:0] value);
    return 20'((value + 32'h0000_0800) >> 5'd12);
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] hi, input logic [4:0] rd);
    return {hi, rd, OP_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] lo, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {lo, rs1, 3'b000, rd, OP_IMM};
  endfunction

  state_t      state_r, state_s;
  logic [4:0]  rd_r, rd_s;
  logic [11:0] lo_r, lo_s;
  logic [31:0] inst_r, inst_s;
  logic        inst_valid_r, inst_valid_s;
  logic        inst_last_r, inst_last_s;

  logic [11:0] lo_in_s;
  logic [19:0] hi_in_s;
  logic        small_s;
  logic [31:0] first_word_s;
  logic        first_last_s;

  // Classify the incoming request and pick the first word of its sequence.
  always_comb begin
    lo_in_s      = bus.req_value[11:0];
    hi_in_s      = split_hi(bus.req_value);
    small_s      = (&bus.req_value[31:11]) | ~(|bus.req_value[31:11]);
    first_word_s = NOP_WORD;
    first_last_s = 1'b1;
    if (bus.req_rd == 5'd0) begin
      first_word_s = NOP_WORD;
      first_last_s = 1'b1;
    end else if (small_s) begin
      first_word_s = enc_addi(lo_in_s, 5'd0, bus.req_rd);
      first_last_s = 1'b1;
    end else if ((lo_in_s == 12'h000) && (SKIP_ZERO_LO == 1'b1)) begin
      first_word_s = enc_lui(hi_in_s, bus.req_rd);
      first_last_s = 1'b1;
    end else begin
      first_word_s = enc_lui(hi_in_s, bus.req_rd);
      first_last_s = 1'b0;
    end
  end

  // Next-state and next-output logic; words are held unchanged while stalled.
  always_comb begin
    state_s      = state_r;
    rd_s         = rd_r;
    lo_s         = lo_r;
    inst_s       = inst_r;
    inst_valid_s = inst_valid_r;
    inst_last_s  = inst_last_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          rd_s         = bus.req_rd;
          lo_s         = lo_in_s;
          inst_s       = first_word_s;
          inst_valid_s = 1'b1;
          inst_last_s  = first_last_s;
          state_s      = EMIT_FIRST;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT_FIRST: begin
        if (bus.inst_ready && inst_last_r) begin
          inst_valid_s = 1'b0;
          state_s      = IDLE;
        end else if (bus.inst_ready) begin
          inst_s      = enc_addi(lo_r, rd_r, rd_r);
          inst_last_s = 1'b1;
          state_s     = EMIT_ADDI;
        end else begin
          state_s = EMIT_FIRST;
        end
      end
      EMIT_ADDI: begin
        if (bus.inst_ready) begin
          inst_valid_s = 1'b0;
          state_s      = IDLE;
        end else begin
          state_s = EMIT_ADDI;
        end
      end
      default: begin
        inst_valid_s = 1'b0;
        inst_last_s  = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= IDLE;
      rd_r         <= 5'd0;
      lo_r         <= 12'h000;
      inst_r       <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
      inst_last_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      rd_r         <= rd_s;
      lo_r         <= lo_s;
      inst_r       <= inst_s;
      inst_valid_r <= inst_valid_s;
      inst_last_r  <= inst_last_s;
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.inst_last  = inst_last_r;
  assign busy           = (state_r != IDLE);
endmodule

// File: tb/tb_li_expander.sv
// Scoreboard bench for li_expander: one instance per SKIP_ZERO_LO setting, driven in lockstep.
module tb_li_expander;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic        req_valid;
  logic [4:0]  req_rd;
  logic [31:0] req_value;
  logic        inst_ready;
  logic        busy1, busy0;
  int          rdy_mode;

  li_expander_if bus1();
  li_expander_if bus0();

  assign bus1.req_valid  = req_valid;
  assign bus1.req_rd     = req_rd;
  assign bus1.req_value  = req_value;
  assign bus1.inst_ready = inst_ready;
  assign bus0.req_valid  = req_valid;
  assign bus0.req_rd     = req_rd;
  assign bus0.req_value  = req_value;
  assign bus0.inst_ready = inst_ready;

  li_expander #(.SKIP_ZERO_LO(1'b1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1), .busy(busy1));
  li_expander #(.SKIP_ZERO_LO(1'b0)) dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0), .busy(busy0));

  int          checks = 0;
  int          errors = 0;
  logic [32:0] expq [2][$];
  logic [36:0] reqq [2][$];
  logic [31:0] acc [2];
  bit          stall_f [2];
  bit          want_valid [2];
  bit          want_idle [2];
  logic [31:0] prev_w [2];
  logic        prev_last [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  task automatic exp_w(input int i, input logic [31:0] w, input logic last);
    expq[i].push_back({last, w});
  endtask

  task automatic note_req(input logic [4:0] rd, input logic [31:0] v);
    reqq[0].push_back({rd, v});
    reqq[1].push_back({rd, v});
  endtask

  // Reference expansion used for the random sweep.
  task automatic push_model(input int i, input bit skip, input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] t;
    logic [11:0] lo;
    lo = v[11:0];
    t  = v + 32'h0000_0800;
    if (rd == 5'd0) exp_w(i, 32'h0000_0013, 1'b1);
    else if (v[31:11] == 21'h0 || v[31:11] == 21'h1F_FFFF) exp_w(i, {lo, 5'd0, 3'b000, rd, 7'h13}, 1'b1);
    else if (lo == 12'h000 && skip) exp_w(i, {t[31:12], rd, 7'h37}, 1'b1);
    else begin
      exp_w(i, {t[31:12], rd, 7'h37}, 1'b0);
      exp_w(i, {lo, rd, 3'b000, rd, 7'h13}, 1'b1);
    end
  endtask

  task automatic mon_step(input int i, input logic v, input logic r, input logic last,
                          input logic [31:0] w, input logic rr, input logic rqv);
    logic [32:0] e;
    logic [36:0] q;
    if (want_valid[i]) check($sformatf("d%0d_valid_latency", i), {31'd0, v}, 32'd1);
    want_valid[i] = 1'b0;
    if (want_idle[i]) check($sformatf("d%0d_ready_after_last", i), {31'd0, rr}, 32'd1);
    want_idle[i] = 1'b0;
    if (stall_f[i]) begin
      check($sformatf("d%0d_stall_valid", i), {31'd0, v}, 32'd1);
      check($sformatf("d%0d_stall_inst", i), w, prev_w[i]);
      check($sformatf("d%0d_stall_last", i), {31'd0, last}, {31'd0, prev_last[i]});
    end
    if (v) check($sformatf("d%0d_req_ready_low", i), {31'd0, rr}, 32'd0);
    if (rqv && rr) want_valid[i] = 1'b1;
    if (v && r) begin
      if (expq[i].size() == 0) check($sformatf("d%0d_unexpected_word", i), w, 32'd0);
      else begin
        e = expq[i].pop_front();
        check($sformatf("d%0d_inst", i), w, e[31:0]);
        check($sformatf("d%0d_inst_last", i), {31'd0, last}, {31'd0, e[32]});
      end
      if (w[6:0] == 7'h37) acc[i] = {w[31:12], 12'h000};
      else acc[i] = ((w[19:15] == 5'd0) ? 32'd0 : acc[i]) + sext12(w[31:20]);
      if (last) begin
        want_idle[i] = 1'b1;
        if (reqq[i].size() == 0) check($sformatf("d%0d_unexpected_req", i), 32'd1, 32'd0);
        else begin
          q = reqq[i].pop_front();
          if (q[36:32] != 5'd0) begin
            check($sformatf("d%0d_decode_rd", i), {27'd0, w[11:7]}, {27'd0, q[36:32]});
            check($sformatf("d%0d_decode_value", i), acc[i], q[31:0]);
          end
        end
      end else begin
        want_valid[i] = 1'b1;
      end
    end
    stall_f[i]   = v && !r;
    prev_w[i]    = w;
    prev_last[i] = last;
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < 2; k++) begin
        stall_f[k] = 1'b0; want_valid[k] = 1'b0; want_idle[k] = 1'b0;
      end
    end else begin
      mon_step(1, bus1.inst_valid, inst_ready, bus1.inst_last, bus1.inst, bus1.req_ready, req_valid);
      mon_step(0, bus0.inst_valid, inst_ready, bus0.inst_last, bus0.inst, bus0.req_ready, req_valid);
    end
  end

  // Consumer ready: 0 = always ready, 1 = random, 2 = driven by the main sequence.
  always @(posedge CLK) begin
    #1;
    if (rdy_mode == 0) inst_ready = 1'b1;
    else if (rdy_mode == 1) inst_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy1 || busy0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] v);
    wait_idle();
    req_valid = 1'b1;
    req_rd    = rd;
    req_value = v;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d1_valid"}, {31'd0, bus1.inst_valid}, 32'd0);
    check({tag, "_d1_ready"}, {31'd0, bus1.req_ready}, 32'd1);
    check({tag, "_d1_inst"}, bus1.inst, 32'h0000_0000);
    check({tag, "_d1_last"}, {31'd0, bus1.inst_last}, 32'd0);
    check({tag, "_d1_busy"}, {31'd0, busy1}, 32'd0);
    check({tag, "_d0_valid"}, {31'd0, bus0.inst_valid}, 32'd0);
    check({tag, "_d0_busy"}, {31'd0, busy0}, 32'd0);
  endtask

  task automatic both(input logic [31:0] w, input logic last);
    exp_w(0, w, last);
    exp_w(1, w, last);
  endtask

  initial begin
    logic [4:0]  rrd;
    logic [31:0] rv;
    RESET = 1'b1; req_valid = 1'b0; req_rd = 5'd0; req_value = 32'd0;
    inst_ready = 1'b0; rdy_mode = 2;
    for (int k = 0; k < 2; k++) acc[k] = 32'd0;
    #2;
    check_reset_outputs("reset");
    @(posedge CLK);
    #3 RESET = 1'b0;
    rdy_mode = 0;

    note_req(5'd5, 32'h0000_07FF);  both(32'h7FF0_0293, 1'b1);  issue(5'd5, 32'h0000_07FF);
    note_req(5'd1, 32'hFFFF_F800);  both(32'h8000_0093, 1'b1);  issue(5'd1, 32'hFFFF_F800);
    note_req(5'd10, 32'h1234_5678); both(32'h1234_5537, 1'b0);  both(32'h6785_0513, 1'b1);
    issue(5'd10, 32'h1234_5678);
    note_req(5'd2, 32'h0000_0800);  both(32'h0000_1137, 1'b0);  both(32'h8001_0113, 1'b1);
    issue(5'd2, 32'h0000_0800);
    note_req(5'd3, 32'h0001_0000);  exp_w(1, 32'h0001_01B7, 1'b1);
    exp_w(0, 32'h0001_01B7, 1'b0);  exp_w(0, 32'h0001_8193, 1'b1);
    issue(5'd3, 32'h0001_0000);
    note_req(5'd4, 32'h8000_0000);  exp_w(1, 32'h8000_0237, 1'b1);
    exp_w(0, 32'h8000_0237, 1'b0);  exp_w(0, 32'h0002_0213, 1'b1);
    issue(5'd4, 32'h8000_0000);
    note_req(5'd6, 32'h7FFF_F800);  both(32'h8000_0337, 1'b0);  both(32'h8003_0313, 1'b1);
    issue(5'd6, 32'h7FFF_F800);
    note_req(5'd0, 32'hDEAD_BEEF);  both(32'h0000_0013, 1'b1);  issue(5'd0, 32'hDEAD_BEEF);

    // Backpressure: three stalled cycles on each word.
    wait_idle();
    rdy_mode = 2; inst_ready = 1'b0;
    note_req(5'd10, 32'h1234_5678); both(32'h1234_5537, 1'b0);  both(32'h6785_0513, 1'b1);
    issue(5'd10, 32'h1234_5678);
    repeat (3) @(posedge CLK);
    #1 inst_ready = 1'b1;
    @(posedge CLK);
    #1 inst_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 inst_ready = 1'b1;
    @(posedge CLK);
    #1 rdy_mode = 0;

    // Reset while the trailing ADDI is pending.
    wait_idle();
    rdy_mode = 2; inst_ready = 1'b0;
    note_req(5'd10, 32'h1234_5678); both(32'h1234_5537, 1'b0);  both(32'h6785_0513, 1'b1);
    issue(5'd10, 32'h1234_5678);
    inst_ready = 1'b1;
    @(posedge CLK);
    #1 inst_ready = 1'b0;
    check("emit_addi_busy", {31'd0, busy1}, 32'd1);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("midreset");
    for (int k = 0; k < 2; k++) begin
      expq[k].delete(); reqq[k].delete(); acc[k] = 32'd0;
    end
    @(posedge CLK);
    #3 RESET = 1'b0;
    rdy_mode = 0;
    repeat (6) begin
      @(negedge CLK);
      check("post_reset_no_word_d1", {31'd0, bus1.inst_valid}, 32'd0);
      check("post_reset_no_word_d0", {31'd0, bus0.inst_valid}, 32'd0);
    end
    check("post_reset_ready", {31'd0, bus1.req_ready}, 32'd1);

    // Random sweep under random backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      rrd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: rv = 32'($urandom_range(0, 4095));
        1: rv = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
        2: rv = {20'($urandom), 12'h000};
        default: rv = $urandom;
      endcase
      note_req(rrd, rv);
      push_model(0, 1'b0, rrd, rv);
      push_model(1, 1'b1, rrd, rv);
      issue(rrd, rv);
    end
    rdy_mode = 0;
    wait_idle();
    repeat (2) @(negedge CLK);
    check("words_drained", 32'(expq[0].size() + expq[1].size()), 32'd0);
    check("reqs_drained", 32'(reqq[0].size() + reqq[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
